// File: rtl/raom_pkg.sv
// Shared definitions for the raom memory arbiter: state encoding and
// default widths / protection boundary.
package raom_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;
  localparam logic [12:0] PROT_TOP_DEF = 13'h02A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WSTRB  = 3'd3,
    ST_WHOLD  = 3'd4,
    ST_ACK    = 3'd5
  } state_t;

endpackage

// File: rtl/raom_arbiter_rr_arb2.sv
// Two-requester round-robin picker. Purely combinational; the "last
// granted" flag is owned by the parent so it only moves on an actual grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // last=1 means port 1 won most recently, so port 0 takes a tie
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last);
    grant[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/raom_arbiter.sv
// Sequencer/arbiter for the shared raom instruction/data memory.
// Port 0 is the CPU path, port 1 the loader/debug port.
// Optional write protection below PROT_TOP is enabled by defining
// RAOM_ARB_WPROT_EN; without it every write is performed and err stays 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | wait for a request, arbitrate, latch winner's command
// RD      | mem_read high, data captured at end of cycle
// WSETUP  | address and data driven, write strobe low
// WSTRB   | write strobe high (memory samples on its rising edge)
// WHOLD   | strobe low, data still driven, winner acked
// ACK     | bus released, winner acked (reads and rejected writes)
module raom_arbiter
  import raom_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter int               DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_TOP = ADDR_W'(PROT_TOP_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  inout  wire  [DATA_W-1:0] mem_data
);

`ifdef RAOM_ARB_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  logic              last;
  logic [1:0]        req, grant;
  logic              take_grant;
  logic              win, win_nxt;
  logic              prot_r, prot_nxt;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              drive_en, drive_nxt;
  logic              ack_nxt, err_nxt;
  logic              sel_we, sel_prot;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {m1_req, m0_req};

  rr_arb2 u_rr (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  // Winner's command mux and protection test on the incoming address
  always_comb begin
    sel_we    = grant[1] ? m1_we    : m0_we;
    sel_addr  = grant[1] ? m1_addr  : m0_addr;
    sel_wdata = grant[1] ? m1_wdata : m0_wdata;
    sel_prot  = WPROT_EN && sel_we && (sel_addr < PROT_TOP);
  end

  // Next state plus next values of the registered strobes, bus enable and acks
  always_comb begin
    state_nxt  = state;
    take_grant = (state == ST_IDLE) && (|req);
    case (state)
      ST_IDLE:   if (|req) state_nxt = sel_we ? ST_WSETUP : ST_RD;
      ST_RD:     state_nxt = ST_ACK;
      ST_WSETUP: state_nxt = prot_r ? ST_ACK : ST_WSTRB;
      ST_WSTRB:  state_nxt = ST_WHOLD;
      ST_WHOLD:  state_nxt = ST_IDLE;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    win_nxt  = take_grant ? grant[1] : win;
    prot_nxt = take_grant ? sel_prot : prot_r;
    // A rejected write sits in WSETUP without ever touching the bus
    drive_nxt = ((state_nxt == ST_WSETUP) && !prot_nxt) ||
                (state_nxt == ST_WSTRB) || (state_nxt == ST_WHOLD);
    ack_nxt   = (state_nxt == ST_WHOLD) || (state_nxt == ST_ACK);
    err_nxt   = (state == ST_WSETUP) && (state_nxt == ST_ACK);
  end

  // State, latched command and glitch-free registered memory controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      prot_r    <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      drive_en  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      win       <= win_nxt;
      prot_r    <= prot_nxt;
      if (take_grant) begin
        last    <= grant[1];
        addr_r  <= sel_addr;
        wdata_r <= sel_wdata;
      end
      drive_en  <= drive_nxt;
      mem_read  <= (state_nxt == ST_RD);
      mem_write <= (state_nxt == ST_WSTRB);
      m0_ack    <= ack_nxt & ~win_nxt;
      m1_ack    <= ack_nxt &  win_nxt;
      m0_err    <= err_nxt & ~win_nxt;
      m1_err    <= err_nxt &  win_nxt;
    end
  end

  // Read data lands in the winner's holding register at the end of RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == ST_RD) begin
      if (win) m1_rdata <= mem_data;
      else     m0_rdata <= mem_data;
    end
  end

  assign mem_addr = addr_r;
  assign mem_data = drive_en ? wdata_r : {DATA_W{1'bz}};

endmodule

// File: doc/raom_arbiter.md
# raom_arbiter

Sequences the shared 8-bit instruction/data memory (`raom`: 13-bit address, tri-state data bus, level `read`, rising-edge-sensitive `write`) and shares it between two requesters: port 0, the CPU fetch/execute path, and port 1, a loader/debug port. It converts a simple req/ack handshake into correctly ordered `read`/`write`/bus-drive sequences. The memory samples on `posedge write`, so address and data must be set up before the strobe and held after it. Round-robin arbitration between the two ports.

## Interface
- `ADDR_W`, 13, memory address width
- `DATA_W`, 8, memory data width
- `PROT_TOP`, 13'h02A, first unprotected address; only used with `RAOM_ARB_WPROT_EN`
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `m0_req`, `m1_req` in 1 — request; held high until ack
- `m0_we`, `m1_we` in 1 — 1 = write, 0 = read; stable while req
- `m0_addr`, `m1_addr` in ADDR_W — address; stable while req
- `m0_wdata`, `m1_wdata` in DATA_W — write data; stable while req
- `m0_ack`, `m1_ack` out 1 — one-cycle completion pulse, registered
- `m0_rdata`, `m1_rdata` out DATA_W — read data, valid with ack, held until the next read on that port
- `m0_err`, `m1_err` out 1 — write rejected; valid with ack
- `mem_addr` out ADDR_W — to memory `addr`
- `mem_read` out 1 — to memory `read`
- `mem_write` out 1 — to memory `write`
- `mem_data` inout DATA_W — memory data bus

## Operation
- States: IDLE, RD, WSETUP, WSTRB, WHOLD, ACK.
- IDLE: if any req is high, pick the winner, latch its addr, we and wdata, and go to RD (read) or WSETUP (write).
- RD: `mem_read`=1 with `mem_addr` valid. At the end of the cycle, capture `mem_data` into the winner's rdata. Go to ACK.
- WSETUP: drive `mem_addr` and `mem_data`; `mem_write`=0. Go to WSTRB.
- WSTRB: `mem_write`=1; addr and data unchanged. Go to WHOLD.
- WHOLD: `mem_write`=0; data still driven; winner's ack=1. Go to IDLE.
- ACK: winner's ack=1; bus released. Go to IDLE.
- Arbitration is round-robin with a `last` register:
  - on simultaneous requests, the port not granted last wins;
  - a single requester always wins;
  - `last` updates on grant.
- Bus rules:
  - `mem_data` is driven only in WSETUP, WSTRB and WHOLD; Z otherwise.
  - `mem_read` and bus drive are never both active.
  - `mem_write` is high for exactly one cycle per accepted write.
- A req still high in the IDLE cycle after an ack counts as a new request.
- Non-granted ports wait; no starvation: worst-case wait is one transaction.

## Timing
- Reset values:
  - state IDLE, `last`=1 (port 0 wins first tie);
  - `mem_addr`=0, `mem_read`=0, `mem_write`=0, `mem_data`=Z;
  - all ack, err and rdata = 0.
- Reset asserted mid-transaction takes effect immediately. Strobes drop and the bus releases asynchronously; a partially sequenced write may be lost and is not acked.
- Read: req sampled in IDLE (cycle 0); RD in cycle 1; ack in cycle 2; next grant possible in cycle 3.
- Write: ack in cycle 3 (WHOLD); next grant possible in cycle 4.
- `mem_addr` holds its last value in IDLE and ACK.

## Configuration
- `RAOM_ARB_WPROT_EN` defined: a write with latched addr < `PROT_TOP` goes WSETUP→ACK.
  - No bus drive, no `mem_write` pulse.
  - err=1 with ack in cycle 2.
  - Reads are unaffected.
- Undefined: all writes are performed and err is tied to 0.

## Structure
- Package `raom_pkg` holds:
  - state encoding constants;
  - `ADDR_W`/`DATA_W` defaults;
  - `PROT_TOP` default.
- Sub-module `rr_arb2`: 2-request round-robin picker, inputs req[1:0] and last, output one-hot grant. Combinational; `last` lives in the parent.
- The tri-state driver and the FSM live in the top level.

## Test plan
- Port-0 read of addr 0x001 preloaded with 0x08 → `mem_read` high in cycle 1 only, m0_ack in cycle 2 with m0_rdata=0x08.
- Port-1 write of 0x5A to 0x12C → single `mem_write` pulse in cycle 2 with addr 0x12C and bus 0x5A stable in cycles 1–3. A following read of 0x12C returns 0x5A.
- Both ports request reads at the same cycle straight after reset → port 0 acks first, port 1 acks 3 cycles later. Repeated ties alternate grants.
- Reset pulsed during WSTRB → `mem_write`, `mem_read`=0 and `mem_data`=Z immediately. No ack; FSM in IDLE on release.
- With `RAOM_ARB_WPROT_EN`: write to 0x010 → ack+err in cycle 2, no `mem_write`, memory unchanged. Write to 0x02A → normal, err=0.
- Back-to-back port-0 reads with req held high → acks every 3 cycles, bus never driven by the block.
